handshake_constant_check: RTL and testbench
===========================================

# handshake_constant_check

Dataflow consumer that sits at the receiving end of a handshake constant source: it accepts data tokens on an elastic valid/ready input channel, compares each token against a compile-time expected value, and emits a one-bit match token on an elastic output channel through a one-entry output register. It also keeps a sticky error flag with first-mismatch capture and optional saturating match/mismatch counters, for use as an in-circuit checker of constant-producing units.

## Interface
- DATA_WIDTH, 32, width of the checked data token
- EXPECTED, 0 (DATA_WIDTH bits), value every input token must equal
- COUNT_WIDTH, 16, width of each statistics counter
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- ins  input  DATA_WIDTH  data token under check
- ins_valid  input  1  input token present
- ins_ready  output  1  block can accept input token this cycle
- outs  output  1  match result token (1 = ins equalled EXPECTED)
- outs_valid  output  1  result token present
- outs_ready  input  1  downstream accepts result token
- err_sticky  output  1  set on first mismatch, held until reset
- err_data  output  DATA_WIDTH  value of the first mismatching token
- match_count  output  COUNT_WIDTH  accepted tokens equal to EXPECTED
- mismatch_count  output  COUNT_WIDTH  accepted tokens differing from EXPECTED

## Operation
- Input transfer ("accept"): ins_valid && ins_ready on a rising edge. Output transfer ("drain"): outs_valid && outs_ready.
- ins_ready = !outs_valid || outs_ready (combinational; registered result slot is free or being freed).
- On accept: outs <= (ins == EXPECTED), outs_valid <= 1. On drain without accept: outs_valid <= 0, outs holds its last value.
- Accept and drain in the same cycle: slot reloaded with the new result, outs_valid stays 1 (full throughput, one token per cycle).
- outs and outs_valid stable while outs_valid && !outs_ready.
- Mismatch on accept while err_sticky == 0: err_sticky <= 1, err_data <= ins. Later mismatches do not change err_data.
- Counters: on accept, exactly one of match_count / mismatch_count increments; each saturates at all-ones and stays there.
- No state changes on cycles without accept or drain.
- Reset (any time, including mid-transfer): outs_valid = 0, outs = 0, err_sticky = 0, err_data = 0, both counters = 0; a token held in the slot is discarded. Deassertion resumes normal operation on the next edge.

## Timing
- Latency: accept in cycle N -> outs_valid high from cycle N+1.
- ins_ready depends combinationally on outs_ready only; there is no path from ins_valid to ins_ready or from ins to outs_valid.
- Flag and counter updates become visible the cycle after the accept that causes them.
- Equality compare is full DATA_WIDTH, unsigned bitwise; no truncation or extension.

## Configuration
- HANDSHAKE_CONSTANT_CHECK_COUNTERS_EN defined: match_count and mismatch_count implemented as described.
- Not defined: no counter registers; both outputs tied to 0. Handshake, outs, err_sticky and err_data behaviour unchanged.

## Test plan
- Reset, then hold ins_valid=0 for 5 cycles -> outs_valid=0, ins_ready=1, err_sticky=0, all counters 0.
- EXPECTED=32'h0000_00A5, DATA_WIDTH=32; send 4 tokens of 32'hA5 back-to-back with outs_ready=1 -> four outs=1 tokens, one per cycle, each one cycle after its accept; match_count=4, mismatch_count=0.
- Send 32'hA5, 32'h1234, 32'hFFFF with outs_ready=1 -> outs sequence 1,0,0; err_sticky=1; err_data=32'h1234; mismatch_count=2.
- Accept one token, then hold outs_ready=0 for 3 cycles while ins_valid=1 -> ins_ready=0, outs/outs_valid stable; raise outs_ready -> drain and new accept in the same cycle, outs_valid stays 1.
- COUNT_WIDTH=2, with the counters macro defined; send 5 matching tokens -> match_count saturates at 3.
- Assert rst while outs_valid=1 and err_sticky=1 -> all outputs return to reset values immediately; next matching token produces outs=1 with err_sticky=0.

Source files
------------

// File: rtl/handshake_constant_check.sv
// handshake_constant_check: elastic checker comparing each token to EXPECTED, with a one-entry result slot.
// Define HANDSHAKE_CONSTANT_CHECK_COUNTERS_EN to build the saturating match/mismatch counters.
module handshake_constant_check #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED = '0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic                   outs,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic                   err_sticky,
  output logic [DATA_WIDTH-1:0]  err_data,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic [COUNT_WIDTH-1:0] mismatch_count
);
  logic                  outs_q, outs_d, valid_q, valid_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] err_data_q, err_data_d;
  logic                  accept, drain, hit;
  assign ins_ready  = !valid_q || outs_ready;
  assign accept     = ins_valid && ins_ready;
  assign drain      = valid_q && outs_ready;
  assign hit        = ins == EXPECTED;
  assign outs       = outs_q;
  assign outs_valid = valid_q;
  assign err_sticky = err_q;
  assign err_data   = err_data_q;
  always_comb begin
    outs_d     = accept ? hit : outs_q;
    valid_d    = accept ? 1'b1 : (drain ? 1'b0 : valid_q);
    err_d      = err_q || (accept && !hit);
    err_data_d = (accept && !hit && !err_q) ? ins : err_data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outs_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_data_q <= '0;
    end else begin
      outs_q     <= outs_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_data_q <= err_data_d;
    end
  end
`ifdef HANDSHAKE_CONSTANT_CHECK_COUNTERS_EN
  logic [COUNT_WIDTH-1:0] mc_q, mc_d, mmc_q, mmc_d;
  assign match_count    = mc_q;
  assign mismatch_count = mmc_q;
  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    mc_d  = (accept && hit && !(&mc_q)) ? mc_q + 1'b1 : mc_q;
    mmc_d = (accept && !hit && !(&mmc_q)) ? mmc_q + 1'b1 : mmc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_q  <= '0;
      mmc_q <= '0;
    end else begin
      mc_q  <= mc_d;
      mmc_q <= mmc_d;
    end
  end
`else
  assign match_count    = '0;
  assign mismatch_count = '0;
`endif
endmodule

// File: tb/tb_handshake_constant_check.sv
// tb_handshake_constant_check: directed stimulus against a queue-based slot model, plus literal checks.
module tb_handshake_constant_check;
  localparam logic [31:0] EXP = 32'h0000_00A5;
`ifdef HANDSHAKE_CONSTANT_CHECK_COUNTERS_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] ins = '0;
  logic ins_valid = 1'b0, outs_ready = 1'b1;
  logic ins_ready, outs, outs_valid, err_sticky;
  logic [31:0] err_data;
  logic [15:0] match_count, mismatch_count;
  logic ins_ready2, outs2, outs_valid2, err_sticky2;
  logic [31:0] err_data2;
  logic [1:0] match_count2, mismatch_count2;
  int compared = 0, mismatched = 0;
  bit go = 1'b0;
  always #5 clk = ~clk;
  handshake_constant_check #(.DATA_WIDTH(32), .EXPECTED(EXP), .COUNT_WIDTH(16)) u0 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready), .err_sticky(err_sticky),
    .err_data(err_data), .match_count(match_count), .mismatch_count(mismatch_count));
  handshake_constant_check #(.DATA_WIDTH(32), .EXPECTED(EXP), .COUNT_WIDTH(2)) u1 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready2),
    .outs(outs2), .outs_valid(outs_valid2), .outs_ready(outs_ready), .err_sticky(err_sticky2),
    .err_data(err_data2), .match_count(match_count2), .mismatch_count(mismatch_count2));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction
  // Model: the result slot as a queue of at most one entry; mismatching tokens kept in order.
  bit slot[$];
  bit m_outs = 1'b0;
  int mc = 0, mmc = 0;
  logic [31:0] errs[$];
  always @(posedge clk or posedge rst) begin
    bit rdy;
    bit m;
    if (rst) begin
      slot.delete();
      errs.delete();
      m_outs = 1'b0;
      mc = 0;
      mmc = 0;
    end else begin
      rdy = slot.size() == 0 || outs_ready;
      if (slot.size() > 0 && outs_ready) void'(slot.pop_front());
      if (ins_valid && rdy) begin
        m = ins == EXP;
        slot.push_back(m);
        m_outs = m;
        if (m) mc++;
        else begin
          mmc++;
          errs.push_back(ins);
        end
      end
    end
  end
  always @(negedge clk) begin
    logic e_valid, e_err;
    logic [31:0] e_ed;
    if (go) begin
      e_valid = slot.size() != 0;
      e_err = errs.size() > 0;
      e_ed = e_err ? errs[0] : 32'h0;
      chk("outs_valid", 64'(outs_valid), 64'(e_valid));
      chk("outs", 64'(outs), 64'(m_outs));
      chk("ins_ready", 64'(ins_ready), 64'(!e_valid || outs_ready));
      chk("err_sticky", 64'(err_sticky), 64'(e_err));
      chk("err_data", 64'(err_data), 64'(e_ed));
      chk("match_count", 64'(match_count), CEN ? 64'(sat(mc, 16)) : 64'd0);
      chk("mismatch_count", 64'(mismatch_count), CEN ? 64'(sat(mmc, 16)) : 64'd0);
      chk("outs_valid_w2", 64'(outs_valid2), 64'(e_valid));
      chk("outs_w2", 64'(outs2), 64'(m_outs));
      chk("match_count_w2", 64'(match_count2), CEN ? 64'(sat(mc, 2)) : 64'd0);
      chk("mismatch_count_w2", 64'(mismatch_count2), CEN ? 64'(sat(mmc, 2)) : 64'd0);
    end
  end
  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    ins_valid = v;
    ins = d;
    outs_ready = r;
    @(posedge clk);
    #2;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    go = 1'b1;
    repeat (5) cyc(1'b0, 32'h0, 1'b1);
    chk("idle_valid", 64'(outs_valid), 64'd0);
    chk("idle_ready", 64'(ins_ready), 64'd1);
    chk("idle_err", 64'(err_sticky), 64'd0);
    chk("idle_mc", 64'(match_count), 64'd0);
    chk("idle_mmc", 64'(mismatch_count), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, EXP, 1'b1);
      chk("b2b_outs", 64'(outs), 64'd1);
      chk("b2b_valid", 64'(outs_valid), 64'd1);
    end
    cyc(1'b0, 32'h0, 1'b1);
    chk("b2b_drained", 64'(outs_valid), 64'd0);
    chk("b2b_mc", 64'(match_count), CEN ? 64'd4 : 64'd0);
    chk("b2b_mmc", 64'(mismatch_count), 64'd0);
    cyc(1'b1, EXP, 1'b1);
    chk("seq_outs0", 64'(outs), 64'd1);
    cyc(1'b1, 32'h1234, 1'b1);
    chk("seq_outs1", 64'(outs), 64'd0);
    chk("seq_err", 64'(err_sticky), 64'd1);
    chk("seq_errdata", 64'(err_data), 64'h1234);
    cyc(1'b1, 32'hFFFF, 1'b1);
    chk("seq_outs2", 64'(outs), 64'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("seq_errdata_kept", 64'(err_data), 64'h1234);
    chk("seq_mmc", 64'(mismatch_count), CEN ? 64'd2 : 64'd0);
    chk("sat_mc16", 64'(match_count), CEN ? 64'd5 : 64'd0);
    chk("sat_mc2", 64'(match_count2), CEN ? 64'd3 : 64'd0);
    cyc(1'b1, EXP, 1'b0);
    chk("stall_first", 64'(outs_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 32'h7, 1'b0);
      chk("stall_ready", 64'(ins_ready), 64'd0);
      chk("stall_outs", 64'(outs), 64'd1);
      chk("stall_valid", 64'(outs_valid), 64'd1);
    end
    outs_ready = 1'b1;
    #1 chk("stall_release_ready", 64'(ins_ready), 64'd1);
    cyc(1'b1, 32'h7, 1'b1);
    chk("overlap_valid", 64'(outs_valid), 64'd1);
    chk("overlap_outs", 64'(outs), 64'd0);
    cyc(1'b0, 32'h0, 1'b1);
    chk("overlap_drained", 64'(outs_valid), 64'd0);
    chk("overlap_mmc", 64'(mismatch_count), CEN ? 64'd3 : 64'd0);
    cyc(1'b1, EXP, 1'b0);
    chk("pre_rst_valid", 64'(outs_valid), 64'd1);
    chk("pre_rst_err", 64'(err_sticky), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(outs_valid), 64'd0);
    chk("rst_outs", 64'(outs), 64'd0);
    chk("rst_err", 64'(err_sticky), 64'd0);
    chk("rst_errdata", 64'(err_data), 64'd0);
    chk("rst_mc", 64'(match_count), 64'd0);
    chk("rst_mmc", 64'(mismatch_count), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    cyc(1'b1, EXP, 1'b1);
    chk("post_rst_outs", 64'(outs), 64'd1);
    chk("post_rst_valid", 64'(outs_valid), 64'd1);
    chk("post_rst_err", 64'(err_sticky), 64'd0);
    chk("post_rst_mc", 64'(match_count), CEN ? 64'd1 : 64'd0);
    cyc(1'b0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
